// File: rtl/rgb565_fifo_unpack.sv
// rgb565_fifo_unpack: read-side unpacker behind the prefetch async FIFO.
// Pops 32-bit words from the FIFO's show-ahead read port and splits each word
// into two RGB565 pixels, one per pix_req. It also tracks the pixel/line
// position and flags underflow with a fill pixel.
//
// Ports:
//   rd_clk, rd_rst      pixel/read clock, async active-high reset
//   frame_start         flush local state, zero counters, clear underflow
//   pix_req             downstream wants one pixel this cycle
//   fifo_rd_en          pop the FIFO head word (combinational)
//   fifo_rd_vld/data    FIFO show-ahead head word
//   pix_vld/pix_data    registered pixel output, one cycle after pix_req
//   line_end/frame_end  registered qualifiers for the last pixel of a line/frame
//   underflow           sticky, set with the first fill pixel
//
// Build option: define UNPACK_HI_FIRST_EN to emit [31:16] before [15:0].
module rgb565_fifo_unpack #(
  parameter int unsigned PIX_PER_LINE = 1024,
  parameter int unsigned LINES        = 768,
  parameter logic [15:0] FILL_PIX     = 16'h0000
) (
  input  logic        rd_clk,
  input  logic        rd_rst,
  input  logic        frame_start,
  input  logic        pix_req,
  output logic        fifo_rd_en,
  input  logic        fifo_rd_vld,
  input  logic [31:0] fifo_rd_data,
  output logic        pix_vld,
  output logic [15:0] pix_data,
  output logic        line_end,
  output logic        frame_end,
  output logic        underflow
);

  localparam int unsigned XW = (PIX_PER_LINE > 1) ? $clog2(PIX_PER_LINE) : 1;
  localparam int unsigned YW = (LINES > 1) ? $clog2(LINES) : 1;
  localparam logic [XW-1:0] XLast = XW'(PIX_PER_LINE - 1);
  localparam logic [YW-1:0] YLast = YW'(LINES - 1);

  typedef enum logic [1:0] {StEmpty, StHaveLo, StHaveHi} state_e;

  state_e        state_q, state_d;
  logic [31:0]   hold_q, hold_d;
  logic [XW-1:0] x_cnt_q, x_cnt_d;
  logic [YW-1:0] y_cnt_q, y_cnt_d;
  logic          pix_vld_q, line_end_q, frame_end_q, underflow_q;
  logic [15:0]   pix_data_q;
  logic          emit;
  logic          fill;
  logic [15:0]   emit_data;

  // First/second pixel of a word in emission order.
  function automatic logic [15:0] first_half(input logic [31:0] w);
`ifdef UNPACK_HI_FIRST_EN
    return w[31:16];
`else
    return w[15:0];
`endif
  endfunction

  function automatic logic [15:0] second_half(input logic [31:0] w);
`ifdef UNPACK_HI_FIRST_EN
    return w[15:0];
`else
    return w[31:16];
`endif
  endfunction

  // Gated by reset so nothing is popped while the block is held in reset.
  assign fifo_rd_en = fifo_rd_vld && !frame_start && !rd_rst &&
                      (state_q == StEmpty || (state_q == StHaveHi && pix_req));

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    emit      = 1'b0;
    fill      = 1'b0;
    emit_data = FILL_PIX;
    if (frame_start) begin
      state_d = StEmpty;
      hold_d  = '0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (fifo_rd_en) begin
            hold_d = fifo_rd_data;
            if (pix_req) begin
              // Bypass: the word arriving now feeds this request directly.
              emit      = 1'b1;
              emit_data = first_half(fifo_rd_data);
              state_d   = StHaveHi;
            end else begin
              state_d = StHaveLo;
            end
          end else if (pix_req) begin
            emit = 1'b1;
            fill = 1'b1;
          end
        end
        StHaveLo: begin
          if (pix_req) begin
            emit      = 1'b1;
            emit_data = first_half(hold_q);
            state_d   = StHaveHi;
          end
        end
        StHaveHi: begin
          if (pix_req) begin
            emit      = 1'b1;
            emit_data = second_half(hold_q);
            if (fifo_rd_en) begin
              hold_d  = fifo_rd_data;
              state_d = StHaveLo;
            end else begin
              state_d = StEmpty;
            end
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_comb begin
    x_cnt_d = x_cnt_q;
    y_cnt_d = y_cnt_q;
    if (frame_start) begin
      x_cnt_d = '0;
      y_cnt_d = '0;
    end else if (emit) begin
      if (x_cnt_q == XLast) begin
        x_cnt_d = '0;
        y_cnt_d = (y_cnt_q == YLast) ? '0 : y_cnt_q + 1'b1;
      end else begin
        x_cnt_d = x_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state_q     <= StEmpty;
      hold_q      <= '0;
      x_cnt_q     <= '0;
      y_cnt_q     <= '0;
      pix_vld_q   <= 1'b0;
      pix_data_q  <= '0;
      line_end_q  <= 1'b0;
      frame_end_q <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      x_cnt_q     <= x_cnt_d;
      y_cnt_q     <= y_cnt_d;
      pix_vld_q   <= emit;
      if (emit) begin
        pix_data_q <= emit_data;
      end
      line_end_q  <= emit && (x_cnt_q == XLast);
      frame_end_q <= emit && (x_cnt_q == XLast) && (y_cnt_q == YLast);
      if (frame_start) begin
        underflow_q <= 1'b0;
      end else if (fill) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign pix_vld   = pix_vld_q;
  assign pix_data  = pix_data_q;
  assign line_end  = line_end_q;
  assign frame_end = frame_end_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_rgb565_fifo_unpack.sv
module tb_rgb565_fifo_unpack;

  localparam logic [15:0] Fill = 16'hF11F;

  logic        rd_clk = 1'b0;
  logic        rd_rst;
  logic        frame_start;
  logic        pix_req;
  logic        fifo_rd_en;
  logic        fifo_rd_vld;
  logic [31:0] fifo_rd_data;
  logic        pix_vld;
  logic [15:0] pix_data;
  logic        line_end;
  logic        frame_end;
  logic        underflow;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] fq[$];

  always #5 rd_clk = ~rd_clk;

  rgb565_fifo_unpack #(
    .PIX_PER_LINE(4),
    .LINES       (2),
    .FILL_PIX    (Fill)
  ) dut (
    .rd_clk      (rd_clk),
    .rd_rst      (rd_rst),
    .frame_start (frame_start),
    .pix_req     (pix_req),
    .fifo_rd_en  (fifo_rd_en),
    .fifo_rd_vld (fifo_rd_vld),
    .fifo_rd_data(fifo_rd_data),
    .pix_vld     (pix_vld),
    .pix_data    (pix_data),
    .line_end    (line_end),
    .frame_end   (frame_end),
    .underflow   (underflow)
  );

  function automatic logic [15:0] f1(input logic [31:0] w);
`ifdef UNPACK_HI_FIRST_EN
    return w[31:16];
`else
    return w[15:0];
`endif
  endfunction

  function automatic logic [15:0] f2(input logic [31:0] w);
`ifdef UNPACK_HI_FIRST_EN
    return w[15:0];
`else
    return w[31:16];
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Show-ahead FIFO model: head word presented whenever the queue is non-empty.
  task automatic refresh();
    fifo_rd_vld  = (fq.size() != 0);
    fifo_rd_data = (fq.size() != 0) ? fq[0] : 32'h0;
  endtask

  // Called a little after a rising edge; advances one clock and pops if the
  // DUT asked for the head word during that cycle.
  task automatic tick();
    logic en;
    #4;
    en = fifo_rd_en;
    @(posedge rd_clk);
    #1;
    if (en && fq.size() != 0) void'(fq.pop_front());
    refresh();
  endtask

  task automatic chk_pix(input string tag, input logic [15:0] d, input logic le,
                         input logic fe);
    chk({tag, ".vld"}, {31'h0, pix_vld}, 32'h1);
    chk({tag, ".data"}, {16'h0, pix_data}, {16'h0, d});
    chk({tag, ".line_end"}, {31'h0, line_end}, {31'h0, le});
    chk({tag, ".frame_end"}, {31'h0, frame_end}, {31'h0, fe});
  endtask

  initial begin
    logic [31:0] w;
    logic [15:0] e;
    rd_rst       = 1'b1;
    frame_start  = 1'b0;
    pix_req      = 1'b0;
    fifo_rd_vld  = 1'b1;
    fifo_rd_data = 32'h1234_5678;
    @(posedge rd_clk);
    #1;
    chk("rst.pix_vld", {31'h0, pix_vld}, 32'h0);
    chk("rst.pix_data", {16'h0, pix_data}, 32'h0);
    chk("rst.line_end", {31'h0, line_end}, 32'h0);
    chk("rst.frame_end", {31'h0, frame_end}, 32'h0);
    chk("rst.underflow", {31'h0, underflow}, 32'h0);
    chk("rst.fifo_rd_en", {31'h0, fifo_rd_en}, 32'h0);
    refresh();
    rd_rst = 1'b0;

    // Preloaded FIFO, four back-to-back requests.
    fq.push_back(32'hBBBB_AAAA);
    fq.push_back(32'hDDDD_CCCC);
    refresh();
    tick();
    pix_req = 1'b1;
    tick(); chk_pix("pre0", f1(32'hBBBB_AAAA), 1'b0, 1'b0);
    tick(); chk_pix("pre1", f2(32'hBBBB_AAAA), 1'b0, 1'b0);
    tick(); chk_pix("pre2", f1(32'hDDDD_CCCC), 1'b0, 1'b0);
    tick(); chk_pix("pre3", f2(32'hDDDD_CCCC), 1'b1, 1'b0);
    chk("pre.underflow", {31'h0, underflow}, 32'h0);
    pix_req = 1'b0;
    tick();
    chk("pre.idle_vld", {31'h0, pix_vld}, 32'h0);

    // Empty FIFO: fill pixel and sticky underflow.
    pix_req = 1'b1;
    tick(); chk_pix("fill", Fill, 1'b0, 1'b0);
    chk("fill.underflow", {31'h0, underflow}, 32'h1);
    pix_req = 1'b0;
    tick(); tick();
    chk("fill.sticky", {31'h0, underflow}, 32'h1);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("fs.underflow_clr", {31'h0, underflow}, 32'h0);
    chk("fs.no_vld", {31'h0, pix_vld}, 32'h0);

    // Word arrives in the same cycle as the request: bypass.
    fq.push_back(32'h2222_1111);
    refresh();
    pix_req = 1'b1;
    #1;
    chk("byp.rd_en", {31'h0, fifo_rd_en}, 32'h1);
    tick(); chk_pix("byp0", f1(32'h2222_1111), 1'b0, 1'b0);
    tick(); chk_pix("byp1", f2(32'h2222_1111), 1'b0, 1'b0);
    chk("byp.underflow", {31'h0, underflow}, 32'h0);
    pix_req = 1'b0;

    // Line/frame markers over 12 continuous pixels from a fresh frame.
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int i = 0; i < 6; i++) fq.push_back({16'(2 * i + 1), 16'(2 * i)} | 32'hA000_A000);
    refresh();
    pix_req = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      w = {16'(k - k % 2 + 1), 16'(k - k % 2)} | 32'hA000_A000;
      e = (k % 2 == 0) ? f1(w) : f2(w);
      chk_pix($sformatf("cnt%0d", k), e, (k % 4 == 3), (k == 7));
    end
    pix_req = 1'b0;
    tick();
    chk("cnt.underflow", {31'h0, underflow}, 32'h0);

    // frame_start while in HAVE_HI with a request pending.
    fq.push_back(32'h4444_3333);
    fq.push_back(32'h6666_5555);
    refresh();
    pix_req = 1'b1;
    tick(); chk_pix("fsh0", f1(32'h4444_3333), 1'b0, 1'b0);
    frame_start = 1'b1;
    #1;
    chk("fsh.no_pop", {31'h0, fifo_rd_en}, 32'h0);
    tick();
    frame_start = 1'b0;
    chk("fsh.no_vld", {31'h0, pix_vld}, 32'h0);
    fq.push_back(32'h8888_7777);
    refresh();
    tick(); chk_pix("fsh1", f1(32'h6666_5555), 1'b0, 1'b0);
    tick(); chk_pix("fsh2", f2(32'h6666_5555), 1'b0, 1'b0);
    tick(); chk_pix("fsh3", f1(32'h8888_7777), 1'b0, 1'b0);
    tick(); chk_pix("fsh4", f2(32'h8888_7777), 1'b1, 1'b0);

    // Asynchronous reset in the middle of streaming.
    fq.push_back(32'hBBBB_AAAA);
    fq.push_back(32'hDDDD_CCCC);
    refresh();
    tick(); chk_pix("ar0", f1(32'hBBBB_AAAA), 1'b0, 1'b0);
    #2;
    rd_rst = 1'b1;
    #1;
    chk("ar.pix_vld", {31'h0, pix_vld}, 32'h0);
    chk("ar.pix_data", {16'h0, pix_data}, 32'h0);
    chk("ar.line_end", {31'h0, line_end}, 32'h0);
    chk("ar.frame_end", {31'h0, frame_end}, 32'h0);
    chk("ar.underflow", {31'h0, underflow}, 32'h0);
    chk("ar.fifo_rd_en", {31'h0, fifo_rd_en}, 32'h0);
    pix_req = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
